// File: rtl/mcp23017_gpio_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mcp23017_gpio_sync                                                        |
// | Sequences IODIR init and mirrors a 16-bit value onto OLATA/OLATB through  |
// | an MCP23017 byte-writer, with write timeout and a sticky error flag.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mcp23017_gpio_sync #(
    parameter logic [2:0]  HW_ADDR        = 3'b000,
    parameter logic [7:0]  IODIR_A        = 8'h00,
    parameter logic [7:0]  IODIR_B        = 8'h00,
    parameter int unsigned STARTUP_CYCLES = 50000,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] gpio_value,
    input  logic        force_refresh,
    input  logic        clear_error,
    output logic        wr_en,
    output logic [2:0]  hardware_address,
    output logic [7:0]  register_address,
    output logic [7:0]  data_out,
    input  logic        completed,
    output logic        init_done,
    output logic        busy,
    output logic        error
);
    localparam int c_SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam int c_TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_SW-1:0] c_START_LAST = c_SW'(STARTUP_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TO_LAST    = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] c_REG_IODIRA = 8'h00;
    localparam logic [7:0] c_REG_IODIRB = 8'h01;
    localparam logic [7:0] c_REG_OLATA  = 8'h14;
    localparam logic [7:0] c_REG_OLATB  = 8'h15;

    typedef enum logic [2:0] {
        S_STARTUP = 3'd0,
        S_INIT_A  = 3'd1,
        S_INIT_B  = 3'd2,
        S_IDLE    = 3'd3,
        S_WR_A    = 3'd4,
        S_WR_B    = 3'd5
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_wr_en;       // doubles as the ISSUE-cycle marker
    logic [7:0]      r_reg, r_data;
    logic [7:0]      r_shadow_a, r_shadow_b, r_snap_hi;
    logic            r_valid_a, r_valid_b, r_force, r_pend_b;
    logic            r_init_done, r_error;
    logic [c_SW-1:0] r_scnt;
    logic [c_TW-1:0] r_tcnt;

    logic       w_need_a, w_need_b, w_waiting, w_ack, w_timeout, w_adv;
    logic       w_load, w_consume, w_set_init, w_pend_b_nxt;
    logic [7:0] w_load_reg, w_load_data;

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_load_reg   = r_reg;
        w_load_data  = r_data;
        w_consume    = 1'b0;
        w_set_init   = 1'b0;
        w_pend_b_nxt = r_pend_b;
        w_need_a  = !r_valid_a || (gpio_value[7:0]  != r_shadow_a) || r_force;
        w_need_b  = !r_valid_b || (gpio_value[15:8] != r_shadow_b) || r_force;
        w_waiting = !r_wr_en && (r_state != S_STARTUP) && (r_state != S_IDLE);
        w_ack     = w_waiting && completed;
        w_timeout = w_waiting && !completed && (r_tcnt == c_TO_LAST);
        w_adv     = w_ack || w_timeout;

        case (r_state)
            S_STARTUP: begin
                if (r_scnt == c_START_LAST) begin
                    w_state_nxt = S_INIT_A;
                    w_load      = 1'b1;
                    w_load_reg  = c_REG_IODIRA;
                    w_load_data = IODIR_A;
                end
            end
            S_INIT_A: begin
                if (w_adv) begin
                    w_state_nxt = S_INIT_B;
                    w_load      = 1'b1;
                    w_load_reg  = c_REG_IODIRB;
                    w_load_data = IODIR_B;
                end
            end
            S_INIT_B: begin
                if (w_adv) begin
                    w_state_nxt = S_IDLE;
                    w_set_init  = 1'b1;
                end
            end
            S_IDLE: begin
                // B's need is frozen here so the follow-on write uses the same snapshot
                if (w_need_a) begin
                    w_state_nxt  = S_WR_A;
                    w_load       = 1'b1;
                    w_load_reg   = c_REG_OLATA;
                    w_load_data  = gpio_value[7:0];
                    w_consume    = 1'b1;
                    w_pend_b_nxt = w_need_b;
                end else if (w_need_b) begin
                    w_state_nxt = S_WR_B;
                    w_load      = 1'b1;
                    w_load_reg  = c_REG_OLATB;
                    w_load_data = gpio_value[15:8];
                    w_consume   = 1'b1;
                end
            end
            S_WR_A: begin
                if (w_adv) begin
                    if (r_pend_b) begin
                        w_state_nxt = S_WR_B;
                        w_load      = 1'b1;
                        w_load_reg  = c_REG_OLATB;
                        w_load_data = r_snap_hi;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_WR_B: begin
                if (w_adv) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_STARTUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_STARTUP;
            r_wr_en     <= 1'b0;
            r_reg       <= 8'h00;
            r_data      <= 8'h00;
            r_shadow_a  <= 8'h00;
            r_shadow_b  <= 8'h00;
            r_snap_hi   <= 8'h00;
            r_valid_a   <= 1'b0;
            r_valid_b   <= 1'b0;
            r_force     <= 1'b0;
            r_pend_b    <= 1'b0;
            r_init_done <= 1'b0;
            r_error     <= 1'b0;
            r_scnt      <= '0;
            r_tcnt      <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_en  <= w_load;
            r_pend_b <= w_pend_b_nxt;
            if (w_load) begin
                r_reg  <= w_load_reg;
                r_data <= w_load_data;
            end
            r_scnt <= (r_state == S_STARTUP) ? r_scnt + c_SW'(1) : '0;
            if (w_load) begin
                r_tcnt <= '0;
            end else if (r_tcnt != c_TO_LAST) begin
                r_tcnt <= r_tcnt + c_TW'(1);
            end
            if (r_state == S_IDLE) begin
                r_snap_hi <= gpio_value[15:8];
            end
            // A timed-out write leaves the shadow stale so IDLE retries it
            if (w_ack && r_state == S_WR_A) begin
                r_shadow_a <= r_data;
                r_valid_a  <= 1'b1;
            end
            if (w_ack && r_state == S_WR_B) begin
                r_shadow_b <= r_data;
                r_valid_b  <= 1'b1;
            end
            // A strobe coincident with consumption is satisfied by the write being issued
            if (w_consume) begin
                r_force <= 1'b0;
            end else if (force_refresh) begin
                r_force <= 1'b1;
            end
            if (w_set_init) begin
                r_init_done <= 1'b1;
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end else if (clear_error) begin
                r_error <= 1'b0;
            end
        end
    end

    assign wr_en            = r_wr_en;
    assign hardware_address = HW_ADDR;
    assign register_address = r_reg;
    assign data_out         = r_data;
    assign init_done        = r_init_done;
    assign busy             = (r_state != S_IDLE);
    assign error            = r_error;

endmodule
`default_nettype wire

// File: doc/mcp23017_gpio_sync.md
Name: mcp23017_gpio_sync

Overview:
- Upstream sequencer for the MCP23017 byte-writer (the block with ports wr_en / hardware_address / register_address / data_in / completed).
- After reset it configures port direction (IODIRA, IODIRB).
- It then mirrors a 16-bit output vector onto OLATA/OLATB, issuing one byte write per changed port half. It waits on the writer's completed pulse before issuing the next write.
- It provides timeout detection and a sticky error flag, so higher logic only has to drive a plain 16-bit value.

Parameters:
- HW_ADDR, 3'b000, MCP23017 A2..A0 strap value driven on hardware_address.
- IODIR_A, 8'h00, value written to IODIRA (reg 8'h00) during init; 0 = output.
- IODIR_B, 8'h00, value written to IODIRB (reg 8'h01) during init.
- STARTUP_CYCLES, 50000, clk cycles of hold-off after reset before the first write.
- TIMEOUT_CYCLES, 100000, max clk cycles from wr_en to completed before a write is declared failed.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- gpio_value  in  16  desired output state; [7:0] maps to port A, [15:8] to port B.
- force_refresh  in  1  one-cycle strobe: rewrite both OLAT bytes even if unchanged.
- clear_error  in  1  one-cycle strobe: clears error.
- wr_en  out  1  one-cycle write request to the byte-writer.
- hardware_address  out  3  constant HW_ADDR.
- register_address  out  8  target register, held stable from issue until completed.
- data_out  out  8  byte to write, held stable from issue until completed.
- completed  in  1  one-cycle done pulse from the byte-writer.
- init_done  out  1  high once both IODIR writes have finished (or timed out).
- busy  out  1  high in every state except IDLE.
- error  out  1  sticky; set on any timeout.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state updates occur on the rising edge of clk.
- Reset values:
  - wr_en=0, register_address=0, data_out=0, init_done=0, busy=1, error=0.
  - Shadow-valid flags for A and B = 0; internal force latch = 0.
- Register map (BANK=0): IODIRA 8'h00, IODIRB 8'h01, OLATA 8'h14, OLATB 8'h15.
- States: STARTUP, INIT_A, INIT_B, IDLE, WR_A, WR_B. Each write state has an ISSUE cycle followed by a WAIT phase.
- STARTUP:
  - Counts STARTUP_CYCLES; completed is ignored.
  - This lets a writer transaction orphaned by a mid-operation rst drain, since the writer has no reset.
  - Then goes to INIT_A.
- ISSUE cycle:
  - wr_en=1 for exactly one cycle; register_address and data_out are loaded in that same cycle.
  - Timeout counter cleared.
- WAIT phase:
  - wr_en=0. Advance on completed=1.
  - If the counter reaches TIMEOUT_CYCLES-1 with no completed: error<=1 and advance as if completed, but the shadow byte is NOT updated.
  - A completed seen outside WAIT is ignored.
- Init sequence:
  - INIT_A writes IODIR_A to 8'h00.
  - INIT_B writes IODIR_B to 8'h01.
  - init_done<=1 on leaving INIT_B. It stays high until rst.
- IDLE, evaluated every cycle:
  - snap<=gpio_value.
  - need_a = !valid_a | snap[7:0]!=shadow_a | force. need_b is the same for the B half.
  - need_a: go to WR_A (8'h14, snap[7:0]). Else need_b: go to WR_B (8'h15, snap[15:8]). Else stay.
  - After WR_A: go to WR_B if need_b, computed on the same snap; otherwise IDLE.
  - force is cleared when it is consumed at entry to WR_A/WR_B.
- Successful completion: shadow<=data_out and valid<=1 for that half.
- gpio_value changes during a transaction do not alter the in-flight bytes. They are picked up at the next IDLE evaluation.
- A failed (timed-out) write leaves the shadow stale, so it is retried from IDLE automatically.
- force_refresh:
  - Latched in any state. Multiple strobes before consumption merge into one.
  - Strobes during STARTUP/INIT are honoured at the first IDLE.
- Error flag:
  - clear_error clears error.
  - clear_error and a timeout in the same cycle: error=1 (the set wins).
- rst mid-operation returns to STARTUP from any state. Shadows are invalidated, so both OLAT bytes are rewritten after re-init.
- Minimum spacing: the next wr_en comes ≥1 cycle after completed.

Test Plan:
- Reset, model writer acks 30 cycles after wr_en, STARTUP_CYCLES=16 → no wr_en for 16 cycles. Writes in order: (8'h00,8'h00), (8'h01,8'h00), (8'h14,A5h), (8'h15,3Ch) for gpio_value=16'h3CA5. init_done rises after the second write; busy=0 afterwards.
- Idle with gpio_value=16'h3CA5, change to 16'h3CFF → exactly one write (8'h14,8'hFF). Change to 16'h00FF → exactly one write (8'h15,8'h00).
- Change gpio_value 3 times during a pending write, final value 16'h1234 → after the current ack, OLAT writes carry 34h/12h only. Bytes stay stable during each WAIT phase.
- Model never asserts completed, TIMEOUT_CYCLES=64 → error=1 at cycle 64 after wr_en, followed by the next write. Same-cycle clear_error still leaves error=1. A later standalone clear_error clears it.
- force_refresh pulsed twice in idle with unchanged value → exactly one A write and one B write with current values.
- rst asserted during WAIT of WR_A, with a stray completed pulse arriving during STARTUP → the pulse is ignored. The full init sequence plus both OLAT writes repeat.
